fma_round_pipe: RTL

- Parametrised, pipelined rounding stage for the fused multiply-add datapath; sits between the normalisation shifter and the result register.
- Takes a normalised sign/exponent/fraction with guard and sticky bits and produces an IEEE-754 packed result plus overflow/inexact flags.
- Generalises the single-cycle half-precision rounder to any NE/NF, a 3-bit rounding mode, a 2-stage valid/ready pipeline and a sticky flag accumulator.

---
 rtl/fma_round_pipe.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fma_round_pipe.sv
// fma_round_pipe: two-stage valid/ready rounding stage for the FMA datapath.
// The first stage registers the normalised operand and a decoded round
// operation. The second stage applies it and registers the packed IEEE result
// together with the overflow and inexact flags.
// Compile-time option: define FMA_RNMM_EN to give roundmode 3'b100
// round-to-nearest-ties-away behaviour. When it is undefined, 3'b100 is
// handled as RNE and no RNMM logic is built.
module fma_round_pipe #(
    parameter int NF = 10,
    parameter int NE = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       roundmode,
    input  logic             m_sign,
    input  logic [NE+1:0]    m_exp,
    input  logic [NF-1:0]    m_fract,
    input  logic             guard,
    input  logic             sticky,
    input  logic             diff_sign,
    input  logic             kill_z,
    input  logic             p_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NE+NF:0]   out_result,
    output logic             out_of,
    output logic             out_nx,
    output logic [1:0]       acc_flags,
    input  logic             flag_clr
);

    localparam int EW = NE + 2;
    localparam logic [EW:0] EMAX = (EW+1)'(2**NE - 2);

    localparam logic [2:0] RM_RZ  = 3'b000;
    localparam logic [2:0] RM_RNE = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
`ifdef FMA_RNMM_EN
    localparam logic [2:0] RM_RNMM = 3'b100;
`endif

    localparam logic [2:0] OP_TRUNC = 3'd0;
    localparam logic [2:0] OP_RND   = 3'd1;
    localparam logic [2:0] OP_P_INF = 3'd2;
    localparam logic [2:0] OP_N_INF = 3'd3;
    localparam logic [2:0] OP_P_MAX = 3'd4;
    localparam logic [2:0] OP_N_MAX = 3'd5;

    // Returns the packed INF or MAX pattern that an overflow op selects.
    function automatic logic [NE+NF:0] enc_special(input logic [2:0] op);
        logic [NE+NF:0] r;
        case (op)
            OP_P_INF: r = {1'b0, {NE{1'b1}}, {NF{1'b0}}};
            OP_N_INF: r = {1'b1, {NE{1'b1}}, {NF{1'b0}}};
            OP_N_MAX: r = {1'b1, EMAX[NE-1:0], {NF{1'b1}}};
            default:  r = {1'b0, EMAX[NE-1:0], {NF{1'b1}}};
        endcase
        return r;
    endfunction

    logic [2:0]      mode_eff;
    logic            sign_sel;
    logic            ovf0;
    logic            rnd_sel;
    logic [2:0]      ovf_op;
    logic [2:0]      op_sel;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_sign_q, s1_sign_d;
    logic [EW-1:0]   s1_exp_q, s1_exp_d;
    logic [NF-1:0]   s1_fract_q, s1_fract_d;
    logic [2:0]      s1_op_q, s1_op_d;
    logic [2:0]      s1_ovf_op_q, s1_ovf_op_d;
    logic            s1_inexact_q, s1_inexact_d;

    logic            s2_valid_q, s2_valid_d;
    logic [NE+NF:0]  result_q, result_d;
    logic            of_q, of_d;
    logic            nx_q, nx_d;
    logic [1:0]      acc_q, acc_d;

    logic            s1_adv, s2_adv, load_s1, load_s2, hs;
    logic [NF+1:0]   inc;
    logic [EW:0]     exp_p1;
    logic [NE+NF:0]  rnd_result;
    logic            rnd_ovf;

    // Decode the incoming beat into its result sign and round operation.
    always_comb begin
        mode_eff = roundmode;
        if (roundmode[2]) mode_eff = RM_RNE;
`ifdef FMA_RNMM_EN
        if (roundmode == RM_RNMM) mode_eff = RM_RNMM;
`endif
        sign_sel = m_sign;
        if ((m_exp == '0) && (m_fract == '0) && diff_sign) begin
            if (kill_z & (guard | sticky)) sign_sel = p_sign;
            else                           sign_sel = (mode_eff == RM_RDN);
        end
        ovf0 = {1'b0, m_exp} > EMAX;
        case (mode_eff)
            RM_RZ:   ovf_op = sign_sel ? OP_N_MAX : OP_P_MAX;
            RM_RDN:  ovf_op = sign_sel ? OP_N_INF : OP_P_MAX;
            RM_RUP:  ovf_op = sign_sel ? OP_N_MAX : OP_P_INF;
            default: ovf_op = sign_sel ? OP_N_INF : OP_P_INF;
        endcase
        case (mode_eff)
            RM_RZ:   rnd_sel = 1'b0;
            RM_RDN:  rnd_sel = sign_sel & (guard | sticky);
            RM_RUP:  rnd_sel = ~sign_sel & (guard | sticky);
`ifdef FMA_RNMM_EN
            RM_RNMM: rnd_sel = guard;
`endif
            default: rnd_sel = guard & (m_fract[0] | sticky);
        endcase
        op_sel = ovf0 ? ovf_op : (rnd_sel ? OP_RND : OP_TRUNC);
    end

    // Apply the stage-1 round op. A carry out of the fraction can overflow the exponent.
    always_comb begin
        inc        = {1'b0, 1'b1, s1_fract_q} + (NF+2)'(1);
        exp_p1     = {1'b0, s1_exp_q} + (EW+1)'(1);
        rnd_ovf    = 1'b0;
        rnd_result = {s1_sign_q, s1_exp_q[NE-1:0], s1_fract_q};
        case (s1_op_q)
            OP_TRUNC: rnd_ovf = 1'b0;
            OP_RND: begin
                if (inc[NF+1]) begin
                    rnd_ovf = exp_p1 > EMAX;
                    if (rnd_ovf) rnd_result = enc_special(s1_ovf_op_q);
                    else         rnd_result = {s1_sign_q, exp_p1[NE-1:0], inc[NF:1]};
                end else begin
                    rnd_result = {s1_sign_q, s1_exp_q[NE-1:0], inc[NF-1:0]};
                end
            end
            default: begin
                rnd_ovf    = 1'b1;
                rnd_result = enc_special(s1_op_q);
            end
        endcase
    end

    // Pipeline handshake, next-state of both stages and the sticky flag accumulator.
    always_comb begin
        s2_adv  = ~s2_valid_q | out_ready;
        s1_adv  = ~s1_valid_q | s2_adv;
        load_s1 = in_valid & s1_adv;
        load_s2 = s2_adv & s1_valid_q;
        hs      = s2_valid_q & out_ready;

        s1_valid_d   = s1_adv ? in_valid : s1_valid_q;
        s1_sign_d    = load_s1 ? sign_sel : s1_sign_q;
        s1_exp_d     = load_s1 ? m_exp : s1_exp_q;
        s1_fract_d   = load_s1 ? m_fract : s1_fract_q;
        s1_op_d      = load_s1 ? op_sel : s1_op_q;
        s1_ovf_op_d  = load_s1 ? ovf_op : s1_ovf_op_q;
        s1_inexact_d = load_s1 ? (guard | sticky) : s1_inexact_q;

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        result_d   = load_s2 ? rnd_result : result_q;
        of_d       = load_s2 ? rnd_ovf : of_q;
        nx_d       = load_s2 ? (s1_inexact_q | rnd_ovf) : nx_q;

        // A handshake coinciding with a clear leaves only that beat's flags.
        acc_d = flag_clr ? 2'b00 : acc_q;
        if (hs) acc_d = acc_d | {of_q, nx_q};
    end

    // State registers; reset discards any beat in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_fract_q   <= '0;
            s1_op_q      <= OP_TRUNC;
            s1_ovf_op_q  <= OP_P_INF;
            s1_inexact_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            result_q     <= '0;
            of_q         <= 1'b0;
            nx_q         <= 1'b0;
            acc_q        <= 2'b00;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_fract_q   <= s1_fract_d;
            s1_op_q      <= s1_op_d;
            s1_ovf_op_q  <= s1_ovf_op_d;
            s1_inexact_q <= s1_inexact_d;
            s2_valid_q   <= s2_valid_d;
            result_q     <= result_d;
            of_q         <= of_d;
            nx_q         <= nx_d;
            acc_q        <= acc_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign out_of     = of_q;
    assign out_nx     = nx_q;
    assign acc_flags  = acc_q;

endmodule
